// File: rtl/i2c_arbiter.sv
// Arbitrates N requesters onto one I2C master: latches the winner's command, issues start, tracks ready, times out.
// Define I2C_ARB_FIXED_PRI_EN for fixed priority (lowest index wins) instead of round-robin.
module i2c_arbiter #(
  parameter int N              = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CW             = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req,
  input  logic [7*N-1:0]    req_addr,
  input  logic [16*N-1:0]   req_data,
  input  logic [N-1:0]      req_rw,
  input  logic [N-1:0]      req_two_bytes,
  output logic [N-1:0]      gnt,
  output logic [N-1:0]      done,
  output logic              err,
  output logic [15:0]       rdata,
  output logic              m_start,
  output logic [6:0]        m_addr,
  output logic [15:0]       m_data,
  output logic              m_rw,
  output logic              m_two_bytes,
  input  logic              m_ready,
  input  logic [15:0]       m_read_data
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, ISSUE, ACCEPT, BUSY, DONE} state_t;

  state_t state, state_n;
  logic [N-1:0]        gnt_n;
  logic [CW-1:0]       cnt, cnt_n;
  logic                abort, abort_n;
  logic [15:0]         rdata_n;
  logic                latch;
  logic                found;
  logic [PW-1:0]       pick;

  logic [N-1:0][6:0]   addr_v;
  logic [N-1:0][15:0]  data_v;
  assign addr_v = req_addr;
  assign data_v = req_data;

`ifndef I2C_ARB_FIXED_PRI_EN
  logic [PW-1:0] ptr, ptr_n, win, win_n;
`endif

  // Winner search; iterate from the lowest-priority candidate so the highest one is assigned last.
  always_comb begin
    found = 1'b0;
    pick  = '0;
`ifdef I2C_ARB_FIXED_PRI_EN
    for (int k = N - 1; k >= 0; k--) begin
      if (req[k]) begin
        found = 1'b1;
        pick  = PW'(k);
      end
    end
`else
    for (int k = N; k >= 1; k--) begin
      logic [PW-1:0] cand;
      cand = PW'((int'(ptr) + k) % N);
      if (req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
`endif
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    cnt_n   = cnt;
    abort_n = abort;
    rdata_n = rdata;
    latch   = 1'b0;
`ifndef I2C_ARB_FIXED_PRI_EN
    ptr_n   = ptr;
    win_n   = win;
`endif
    case (state)
      IDLE: begin
        if (m_ready && found) begin
          latch   = 1'b1;
          gnt_n   = {{(N-1){1'b0}}, 1'b1} << pick;
          abort_n = 1'b0;
          state_n = ISSUE;
`ifndef I2C_ARB_FIXED_PRI_EN
          win_n   = pick;
`endif
        end
      end
      ISSUE: begin
        cnt_n   = '0;
        state_n = ACCEPT;
      end
      ACCEPT: begin
        cnt_n = cnt + 1'b1;
        if (cnt == TO_LAST) begin
          abort_n = 1'b1;
          rdata_n = '0;
          state_n = DONE;
        end else if (!m_ready) begin
          state_n = BUSY;
        end
      end
      BUSY: begin
        cnt_n = cnt + 1'b1;
        // A completion seen on the last timeout cycle still counts as a good transfer.
        if (m_ready) begin
          if (m_rw) rdata_n = m_read_data;
          state_n = DONE;
        end else if (cnt == TO_LAST) begin
          abort_n = 1'b1;
          rdata_n = '0;
          state_n = DONE;
        end
      end
      DONE: begin
        gnt_n   = '0;
        state_n = IDLE;
`ifndef I2C_ARB_FIXED_PRI_EN
        ptr_n   = win;
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  // Pulsed outputs are registered from next-state so they align with the state they belong to.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      gnt         <= '0;
      done        <= '0;
      err         <= 1'b0;
      m_start     <= 1'b0;
      cnt         <= '0;
      abort       <= 1'b0;
      rdata       <= '0;
      m_addr      <= '0;
      m_data      <= '0;
      m_rw        <= 1'b0;
      m_two_bytes <= 1'b0;
    end else begin
      state   <= state_n;
      gnt     <= gnt_n;
      done    <= (state_n == DONE) ? gnt_n : '0;
      err     <= (state_n == DONE) && abort_n;
      m_start <= (state_n == ISSUE);
      cnt     <= cnt_n;
      abort   <= abort_n;
      rdata   <= rdata_n;
      if (latch) begin
        m_addr      <= addr_v[pick];
        m_data      <= data_v[pick];
        m_rw        <= req_rw[pick];
        m_two_bytes <= req_two_bytes[pick];
      end
    end
  end

`ifndef I2C_ARB_FIXED_PRI_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= PW'(N - 1);
      win <= '0;
    end else begin
      ptr <= ptr_n;
      win <= win_n;
    end
  end
`endif

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter with a behavioural master and start/done scoreboards.
module tb_i2c_arbiter;
  localparam int N   = 4;
  localparam int TMO = 64;

  logic          clk, rst;
  logic [N-1:0]  req, req_rw, req_two_bytes;
  logic [27:0]   req_addr;
  logic [63:0]   req_data;
  logic [N-1:0]  gnt, done;
  logic          err, m_start, m_rw, m_two_bytes, m_ready;
  logic [15:0]   rdata, m_data, m_read_data;
  logic [6:0]    m_addr;

  i2c_arbiter #(.N(N), .TIMEOUT_CYCLES(TMO), .CW(11)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .req_rw(req_rw), .req_two_bytes(req_two_bytes), .gnt(gnt), .done(done), .err(err),
    .rdata(rdata), .m_start(m_start), .m_addr(m_addr), .m_data(m_data), .m_rw(m_rw),
    .m_two_bytes(m_two_bytes), .m_ready(m_ready), .m_read_data(m_read_data)
  );

  typedef struct packed { logic [6:0] a; logic [15:0] d; logic rw; logic tb; logic [3:0] g; } st_t;
  typedef struct packed { logic [3:0] g; logic e; logic [15:0] rd; } dn_t;
  st_t start_q[$];
  dn_t done_q[$];

  int n_chk = 0, n_pass = 0, n_fail = 0;
  int cyc = 0, rise_cyc = 0, st_cyc = 0;
  int mst_lat = 10;
  bit mst_hang = 0;
  logic [15:0] mst_rd = 16'h0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [6:0] a, input logic [15:0] d,
                         input logic rw, input logic tb);
    req_addr[7*i +: 7]  = a;
    req_data[16*i +: 16] = d;
    req_rw[i]           = rw;
    req_two_bytes[i]    = tb;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int i;
    for (i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done != '0) break;
    end
    chk(tag, 32'(i < lim), 1);
  endtask

  // Behavioural master: drops ready on start, returns it after mst_lat cycles unless hung.
  initial begin
    m_ready = 1'b1;
    m_read_data = 16'h0;
    forever begin
      @(negedge clk);
      if (m_start && rst) begin
        m_ready = 1'b0;
        if (!mst_hang) begin
          repeat (mst_lat) @(negedge clk);
          m_read_data = mst_rd;
          m_ready = 1'b1;
          rise_cyc = cyc;
        end
      end
    end
  end

  // Scoreboard monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (gnt != '0) begin
        chk("gnt_onehot", 32'($onehot(gnt)), 1);
        chk("done_subset", 32'(done & ~gnt), 0);
      end
      if (m_start && rst) begin
        st_cyc = cyc;
        if (start_q.size() == 0) chk("start_unexpected", 1, 0);
        else begin
          st_t e;
          e = start_q.pop_front();
          chk("start_addr", 32'(m_addr), 32'(e.a));
          chk("start_data", 32'(m_data), 32'(e.d));
          chk("start_rw_two", 32'({m_rw, m_two_bytes}), 32'({e.rw, e.tb}));
          chk("start_gnt", 32'(gnt), 32'(e.g));
        end
      end
      if (done != '0) begin
        if (done_q.size() == 0) chk("done_unexpected", 32'(done), 0);
        else begin
          dn_t e;
          e = done_q.pop_front();
          chk("done_vec", 32'(done), 32'(e.g));
          chk("done_err", 32'(err), 32'(e.e));
          chk("done_rdata", 32'(rdata), 32'(e.rd));
          if (e.e) chk("timeout_latency", 32'(cyc - st_cyc), 32'(TMO + 1));
          else     chk("ready_to_done", 32'(cyc - rise_cyc), 1);
        end
      end else if (err) begin
        chk("err_without_done", 32'(err), 0);
      end
    end
  end

  initial begin
    rst = 1'b0; req = '0; req_rw = '0; req_two_bytes = '0; req_addr = '0; req_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 0);
    chk("rst_done_err", 32'({done, err}), 0);
    chk("rst_mstart", 32'(m_start), 0);
    chk("rst_maddr", 32'(m_addr), 0);
    chk("rst_mdata", 32'(m_data), 0);
    chk("rst_rdata", 32'(rdata), 0);
    chk("rst_mrw_two", 32'({m_rw, m_two_bytes}), 0);
    rst = 1'b1;
    @(negedge clk);

    // Single write from requester 0
    set_req(0, 7'h50, 16'haa55, 1'b0, 1'b0);
    mst_lat = 20;
    start_q.push_back('{7'h50, 16'haa55, 1'b0, 1'b0, 4'b0001});
    done_q.push_back('{4'b0001, 1'b0, 16'h0});
    req = 4'b0001;
    @(negedge clk);
    chk("t1_gnt", 32'(gnt), 32'h1);
    chk("t1_mstart", 32'(m_start), 1);
    @(negedge clk);
    chk("t1_mstart_pulse", 32'(m_start), 0);
    wait_done("t1_wait", 60);
    req = '0;
    @(negedge clk);
    chk("t1_gnt_clear", 32'(gnt), 0);

    // Two-byte read from requester 2
    set_req(2, 7'h22, 16'h0000, 1'b1, 1'b1);
    mst_lat = 15; mst_rd = 16'h1234;
    start_q.push_back('{7'h22, 16'h0000, 1'b1, 1'b1, 4'b0100});
    done_q.push_back('{4'b0100, 1'b0, 16'h1234});
    req = 4'b0100;
    wait_done("t2_wait", 60);
    req = '0;
    @(negedge clk);
    chk("t2_rdata_hold", 32'(rdata), 32'h1234);

    // Timeout: master never returns ready
    set_req(1, 7'h31, 16'h0bad, 1'b0, 1'b0);
    mst_hang = 1;
    start_q.push_back('{7'h31, 16'h0bad, 1'b0, 1'b0, 4'b0010});
    done_q.push_back('{4'b0010, 1'b1, 16'h0});
    req = 4'b0010;
    wait_done("t4_wait", 120);
    req = '0;
    @(negedge clk);
    chk("t4_idle_gnt", 32'(gnt), 0);
    chk("t4_rdata_zero", 32'(rdata), 0);

    // Master not ready: ready still low from the hung transfer
    mst_hang = 0; mst_lat = 10;
    set_req(1, 7'h11, 16'h5a5a, 1'b0, 1'b0);
    req = 4'b0010;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_no_gnt", 32'({gnt, m_start}), 0);
    end
    start_q.push_back('{7'h11, 16'h5a5a, 1'b0, 1'b0, 4'b0010});
    done_q.push_back('{4'b0010, 1'b0, 16'h0});
    m_ready = 1'b1;
    @(negedge clk);
    chk("t5_gnt", 32'(gnt), 32'h2);
    chk("t5_mstart", 32'(m_start), 1);
    wait_done("t5_wait", 60);
    req = '0;
    @(negedge clk);

    // Async reset while busy
    set_req(3, 7'h7f, 16'hbeef, 1'b0, 1'b0);
    mst_lat = 30;
    start_q.push_back('{7'h7f, 16'hbeef, 1'b0, 1'b0, 4'b1000});
    req = 4'b1000;
    @(negedge clk);
    chk("t6_gnt", 32'(gnt), 32'h8);
    repeat (5) @(negedge clk);
    chk("t6_busy_gnt", 32'(gnt), 32'h8);
    #2 rst = 1'b0;
    #1;
    chk("t6_rst_gnt", 32'(gnt), 0);
    chk("t6_rst_done_start", 32'({done, m_start}), 0);
    chk("t6_rst_maddr", 32'(m_addr), 0);
    req = '0;
    repeat (35) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Contention: all four held
    for (int i = 0; i < N; i++) set_req(i, 7'(8'h10 + i), 16'(16'h1100 * (i + 1)), 1'b0, 1'b0);
    mst_lat = 8;
    for (int k = 0; k < 5; k++) begin
      int w;
`ifdef I2C_ARB_FIXED_PRI_EN
      w = 0;
`else
      w = k % N;
`endif
      start_q.push_back('{7'(8'h10 + w), 16'(16'h1100 * (w + 1)), 1'b0, 1'b0, 4'(1 << w)});
      done_q.push_back('{4'(1 << w), 1'b0, 16'h0});
    end
    req = 4'b1111;
    for (int k = 0; k < 5; k++) wait_done("t3_wait", 60);
    req = '0;

    repeat (5) @(negedge clk);
    chk("start_q_drained", 32'(start_q.size()), 0);
    chk("done_q_drained", 32'(done_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
